// File: rtl/sigmoid_backward_if.sv
// sigmoid_backward_if: valid/ready element stream into and out of the hard-sigmoid gradient unit
interface sigmoid_backward_if #(parameter int DATA_WIDTH = 16);
    logic                  in_valid, in_ready, in_last;
    logic [DATA_WIDTH-1:0] in_x, in_dy;
    logic                  out_valid, out_ready, out_last;
    logic [DATA_WIDTH-1:0] out_dx;
    modport master(output in_valid, in_x, in_dy, in_last, out_ready,
                   input in_ready, out_valid, out_dx, out_last);
    modport slave(input in_valid, in_x, in_dy, in_last, out_ready,
                  output in_ready, out_valid, out_dx, out_last);
endinterface

// File: rtl/sigmoid_backward.sv
// sigmoid_backward: two-stage dX = dY * hard-sigmoid'(X) pipeline with per-vector saturation count
module sigmoid_backward #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sigmoid_backward_if.slave    bus,
    output logic [CNT_WIDTH-1:0] sat_total,
    output logic                 sat_done
);
    localparam logic signed [DATA_WIDTH-1:0] T = DATA_WIDTH'(2) << FRACT_WIDTH;
    logic                         s1_valid, s1_sat, s1_last, s2_valid, s2_sat, s1_adv, out_hs;
    logic        [DATA_WIDTH-1:0] s1_dy;
    logic signed [DATA_WIDTH-1:0] x, dy;
    logic        [CNT_WIDTH-1:0]  running, sat_sum;
    assign x             = bus.in_x;
    assign dy            = bus.in_dy;
    assign out_hs        = s2_valid & bus.out_ready;
    assign s1_adv        = !s2_valid | out_hs;
    assign bus.in_ready  = !s1_valid | s1_adv;
    assign bus.out_valid = s2_valid;
    assign sat_sum       = &running ? running : running + CNT_WIDTH'(s2_sat);
    // stage 1: saturation flag, pre-shifted gradient and last marker
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            s1_last  <= 1'b0;
            s1_dy    <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sat  <= (x > T) || (x < -T);
                s1_dy   <= dy >>> 2;
                s1_last <= bus.in_last;
            end
        end
    // stage 2: zero the gradient in saturation and hold it until accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            s2_sat       <= 1'b0;
            bus.out_dx   <= '0;
            bus.out_last <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sat       <= s1_sat;
                bus.out_dx   <= s1_sat ? '0 : s1_dy;
                bus.out_last <= s1_last;
            end
        end
    // saturated-element count per vector, published on the last element's handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            running   <= '0;
            sat_total <= '0;
            sat_done  <= 1'b0;
        end else begin
            sat_done <= out_hs & bus.out_last;
            if (out_hs) begin
                running <= bus.out_last ? '0 : sat_sum;
                if (bus.out_last) sat_total <= sat_sum;
            end
        end
endmodule
